// File: rtl/alarm_pkg.sv
// Shared definitions for the button conditioner: FSM state encoding,
// default timing constants for a 100 MHz system clock, and a small helper.
package alarm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE            = 2'd0,
        ST_CONFIRM_PRESS   = 2'd1,
        ST_HELD            = 2'd2,
        ST_CONFIRM_RELEASE = 2'd3
    } btn_state_e;

    // 10 ms debounce, 500 ms to first repeat, 200 ms between repeats at 100 MHz
    localparam int DEBOUNCE_DEFAULT      = 1_000_000;
    localparam int REPEAT_DELAY_DEFAULT  = 50_000_000;
    localparam int REPEAT_PERIOD_DEFAULT = 20_000_000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_timer.sv
// Saturating up-counter with synchronous clear and count enable.
// Clear wins over enable; the count sticks at all-ones instead of wrapping.
module button_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // next count: clear, saturating increment, or hold
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // count register, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/button_conditioner.sv
// Debounces a synchronized push-button level and produces press, release
// and auto-repeat pulses. All outputs are registered.
//
// state              | meaning
// -------------------+---------------------------------------------------
// ST_IDLE            | released and stable, waiting for a 1 sample
// ST_CONFIRM_PRESS   | counting consecutive 1 samples toward a press
// ST_HELD            | accepted press; hold timer runs, repeats may fire
// ST_CONFIRM_RELEASE | counting consecutive 0 samples; hold timer frozen
module button_conditioner
    import alarm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEFAULT,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic sig_sync,
    input  logic repeat_en,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);

    // Compare against N-1: the edge that sees the N-th qualifying sample acts.
    localparam logic [DB_W-1:0]   DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'(REPEAT_DELAY - 1);
    localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(REPEAT_PERIOD - 1);

    btn_state_e        state_q, state_d;
    logic [DB_W-1:0]   db_cnt;
    logic              db_clr, db_en;
    logic [HOLD_W-1:0] hold_cnt;
    logic              hold_clr, hold_en, hold_active, tick;
    logic              rep_phase_q, rep_phase_d;
    logic              pressed_q, pressed_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              repeat_q, repeat_d;

    button_timer #(.WIDTH(DB_W)) u_db_timer (
        .clk   (clk),
        .rst   (rst),
        .clr_i (db_clr),
        .en_i  (db_en),
        .cnt_o (db_cnt)
    );

    button_timer #(.WIDTH(HOLD_W)) u_hold_timer (
        .clk   (clk),
        .rst   (rst),
        .clr_i (hold_clr),
        .en_i  (hold_en),
        .cnt_o (hold_cnt)
    );

    // debounce FSM: next state, debounce counter control, press/release events
    always_comb begin
        state_d   = state_q;
        db_clr    = 1'b0;
        db_en     = 1'b0;
        pressed_d = pressed_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sig_sync) begin
                    state_d = ST_CONFIRM_PRESS;
                    db_en   = 1'b1;
                end else begin
                    db_clr = 1'b1;
                end
            end
            ST_CONFIRM_PRESS: begin
                if (!sig_sync) begin
                    state_d = ST_IDLE;
                    db_clr  = 1'b1;
                end else if (db_cnt == DB_LAST) begin
                    state_d   = ST_HELD;
                    db_clr    = 1'b1;
                    pressed_d = 1'b1;
                    press_d   = 1'b1;
                end else begin
                    db_en = 1'b1;
                end
            end
            ST_HELD: begin
                if (!sig_sync) begin
                    state_d = ST_CONFIRM_RELEASE;
                    db_en   = 1'b1;
                end else begin
                    db_clr = 1'b1;
                end
            end
            ST_CONFIRM_RELEASE: begin
                if (sig_sync) begin
                    state_d = ST_HELD;
                    db_clr  = 1'b1;
                end else if (db_cnt == DB_LAST) begin
                    state_d   = ST_IDLE;
                    db_clr    = 1'b1;
                    pressed_d = 1'b0;
                    release_d = 1'b1;
                end else begin
                    db_en = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                db_clr  = 1'b1;
            end
        endcase
    end

    // Hold timer counts only edges that keep the FSM in HELD, so it freezes
    // through a release bounce. After the first tick it restarts per period.
    always_comb begin
        hold_active = (state_q == ST_HELD) && sig_sync;
        tick        = hold_active &&
                      (hold_cnt == (rep_phase_q ? PERIOD_LAST : DELAY_LAST));
        hold_en     = hold_active;
        hold_clr    = tick || press_d;
        rep_phase_d = rep_phase_q;
        if (press_d) begin
            rep_phase_d = 1'b0;
        end else if (tick) begin
            rep_phase_d = 1'b1;
        end
        repeat_d = tick && repeat_en;
    end

    // state and output registers, all forced to zero by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rep_phase_q <= 1'b0;
            pressed_q   <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            repeat_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            rep_phase_q <= rep_phase_d;
            pressed_q   <= pressed_d;
            press_q     <= press_d;
            release_q   <= release_d;
            repeat_q    <= repeat_d;
        end
    end

    assign pressed       = pressed_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign repeat_pulse  = repeat_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner with short timing parameters.
module tb_button_conditioner;

    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic clk;
    logic rst;
    logic sig_sync;
    logic repeat_en;
    logic pressed;
    logic press_pulse;
    logic release_pulse;
    logic repeat_pulse;

    button_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .sig_sync      (sig_sync),
        .repeat_en     (repeat_en),
        .pressed       (pressed),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .repeat_pulse  (repeat_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    string phase = "init";

    // Reference model: accepted level flips after D consecutive samples that
    // differ from it; repeat ticks at RD, RD+RP, RD+2RP ... counted edges
    // spent staying in the held state.
    logic m_pressed, m_press, m_rel, m_rep;
    int   m_run, m_held;

    task automatic model_reset();
        m_pressed = 0; m_press = 0; m_rel = 0; m_rep = 0;
        m_run = 0; m_held = 0;
    endtask

    task automatic model_step(input logic s, input logic en);
        logic stay_held;
        stay_held = m_pressed && s && (m_run == 0);
        m_press = 0; m_rel = 0; m_rep = 0;
        if (s != m_pressed) begin
            m_run++;
            if (m_run == D) begin
                m_pressed = s;
                m_run = 0;
                if (s) begin
                    m_press = 1;
                    m_held = 0;
                end else begin
                    m_rel = 1;
                end
            end
        end else begin
            m_run = 0;
        end
        if (stay_held) begin
            m_held++;
            if (m_held >= RD && ((m_held - RD) % RP) == 0) m_rep = en;
        end
    endtask

    task automatic chk(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL [%s] %s: got %0b expected %0b at t=%0t", phase, name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL [%s] %s: got %0d expected %0d at t=%0t", phase, name, act, exp, $time);
        end
    endtask

    // one sample edge: drive, advance model, clock, compare at negedge
    task automatic step(input logic s, input logic en);
        sig_sync = s;
        repeat_en = en;
        model_step(s, en);
        @(posedge clk);
        @(negedge clk);
        chk("pressed", pressed, m_pressed);
        chk("press_pulse", press_pulse, m_press);
        chk("release_pulse", release_pulse, m_rel);
        chk("repeat_pulse", repeat_pulse, m_rep);
    endtask

    // called at a negedge: reset pulse entirely between two rising edges
    task automatic reset_between_edges();
        #2 rst = 1'b1;
        #1;
        chk("rst_pressed", pressed, 1'b0);
        chk("rst_press", press_pulse, 1'b0);
        chk("rst_release", release_pulse, 1'b0);
        chk("rst_repeat", repeat_pulse, 1'b0);
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic s;
        logic en;
        logic e_pressed;
        logic e_press;
        logic e_rel;
        logic e_rep;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic s, input logic en, input logic p,
                       input logic pp, input logic rl, input logic rp);
        vec_t v;
        v.s = s; v.en = en; v.e_pressed = p; v.e_press = pp; v.e_rel = rl; v.e_rep = rp;
        tbl.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int first_rep;
        int n_rep;
        int n_rel;
        int n_rand_press;
        logic cur;
        logic en;

        rst = 1'b1;
        sig_sync = 1'b0;
        repeat_en = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        phase = "reset";
        chk("pressed", pressed, 1'b0);
        chk("press_pulse", press_pulse, 1'b0);
        chk("release_pulse", release_pulse, 1'b0);
        chk("repeat_pulse", repeat_pulse, 1'b0);
        rst = 1'b0;

        // short glitch, full press, two repeats, clean release
        for (int i = 0; i < 3; i++) add(1, 1, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(1, 1, 0, 0, 0, 0);
        add(1, 1, 1, 1, 0, 0);
        for (int k = 1; k <= 13; k++) add(1, 1, 1, 0, 0, (k == 10 || k == 13) ? 1'b1 : 1'b0);
        for (int i = 0; i < 3; i++) add(0, 1, 1, 0, 0, 0);
        add(0, 1, 0, 0, 1, 0);
        add(0, 1, 0, 0, 0, 0);

        phase = "table";
        for (int i = 0; i < tbl.size(); i++) begin
            sig_sync = tbl[i].s;
            repeat_en = tbl[i].en;
            model_step(tbl[i].s, tbl[i].en);
            @(posedge clk);
            @(negedge clk);
            chk("tbl_pressed", pressed, tbl[i].e_pressed);
            chk("tbl_press", press_pulse, tbl[i].e_press);
            chk("tbl_release", release_pulse, tbl[i].e_rel);
            chk("tbl_repeat", repeat_pulse, tbl[i].e_rep);
        end

        // 30-cycle hold with repeat enabled
        phase = "repeat_on";
        for (int i = 0; i < D; i++) step(1, 1);
        chk("press_at_4th", press_pulse, 1'b1);
        n_rep = 0;
        for (int k = 1; k <= 30; k++) begin
            step(1, 1);
            chk("repeat_slot", repeat_pulse, (k >= 10 && ((k - 10) % 3) == 0) ? 1'b1 : 1'b0);
            if (repeat_pulse) n_rep++;
        end
        chk_int("repeat_count", n_rep, 7);

        // release with one bounce; a tick would fall here if the timer ran
        phase = "bounce";
        n_rep = 0;
        n_rel = 0;
        step(0, 1); if (repeat_pulse) n_rep++; chk("held_b0", pressed, 1'b1);
        step(1, 1); if (repeat_pulse) n_rep++; chk("held_b1", pressed, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(0, 1);
            if (repeat_pulse) n_rep++;
            if (release_pulse) n_rel++;
            chk("held_b2", pressed, 1'b1);
        end
        step(0, 1);
        if (release_pulse) n_rel++;
        chk("released", pressed, 1'b0);
        step(0, 1);
        if (release_pulse) n_rel++;
        chk_int("release_count", n_rel, 1);
        chk_int("repeat_in_release", n_rep, 0);

        // repeat disabled, then enabled from cycle 15
        phase = "repeat_gate";
        for (int i = 0; i < D; i++) step(1, 0);
        first_rep = -1;
        n_rep = 0;
        for (int k = 1; k <= 30; k++) begin
            step(1, (k >= 15) ? 1'b1 : 1'b0);
            if (repeat_pulse) begin
                n_rep++;
                if (first_rep < 0) first_rep = k;
            end
        end
        chk_int("first_repeat", first_rep, 16);
        chk_int("gated_count", n_rep, 5);
        for (int i = 0; i < D + 1; i++) step(0, 0);

        // asynchronous reset while held
        phase = "reset_held";
        for (int i = 0; i < D + 5; i++) step(1, 1);
        chk("held_before_rst", pressed, 1'b1);
        reset_between_edges();
        n_rel = 0;
        for (int i = 0; i < D - 1; i++) begin
            step(1, 1);
            if (release_pulse) n_rel++;
            chk("no_early_press", press_pulse, 1'b0);
        end
        step(1, 1);
        chk("repress_4th", press_pulse, 1'b1);
        chk_int("no_release_after_rst", n_rel, 0);

        // randomized run against the reference model
        phase = "random";
        cur = 1'b1;
        n_rand_press = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 11) == 0) cur = ~cur;
            en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 299) == 0) reset_between_edges();
            step(cur, en);
            if (press_pulse) n_rand_press++;
        end
        n_checks++;
        if (n_rand_press == 0) begin
            n_fail++;
            $display("FAIL [random] press_seen: got 0 presses expected at least 1");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000, meaning consecutive equal samples needed to accept a level change (10 ms at 100 MHz); legal range >= 2.
REQ-002 SHALL have parameter REPEAT_DELAY, default 50_000_000, meaning cycles from press_pulse to first repeat_pulse; legal range >= 2.
REQ-003 SHALL have parameter REPEAT_PERIOD, default 20_000_000, meaning cycles between subsequent repeat_pulses; legal range >= 2.
REQ-004 clk  input  1  single system clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 sig_sync  input  1  button level, already two-flop synchronized to clk; 1 = pressed.
REQ-007 repeat_en  input  1  1 = auto-repeat enabled while held.
REQ-008 pressed  output  1  debounced button level (registered).
REQ-009 press_pulse  output  1  one-cycle pulse on accepted press.
REQ-010 release_pulse  output  1  one-cycle pulse on accepted release.
REQ-011 repeat_pulse  output  1  one-cycle auto-repeat pulse while held.

Function
REQ-012 SHALL implement FSM states IDLE, CONFIRM_PRESS, HELD, CONFIRM_RELEASE.
REQ-013 IDLE: sig_sync=1 sampled -> CONFIRM_PRESS, debounce count = 1; otherwise stay.
REQ-014 CONFIRM_PRESS: each sample of 1 increments count; any sample of 0 -> IDLE, count cleared.
REQ-015 On the DEBOUNCE_CYCLES-th consecutive 1 sample: -> HELD; pressed=1 and press_pulse=1 for exactly the following cycle.
REQ-016 HELD: sig_sync=0 sampled -> CONFIRM_RELEASE, count = 1; pressed stays 1.
REQ-017 CONFIRM_RELEASE: any 1 sample -> HELD, count cleared, no press_pulse; DEBOUNCE_CYCLES-th consecutive 0 -> IDLE, pressed=0, release_pulse=1 for the following cycle.
REQ-018 Hold timer SHALL clear on entry to HELD from CONFIRM_PRESS, count only in HELD, freeze in CONFIRM_RELEASE, resume on return to HELD.
REQ-019 Internal repeat tick SHALL occur exactly REPEAT_DELAY HELD-cycles after press_pulse, then every REPEAT_PERIOD HELD-cycles thereafter.
REQ-020 repeat_pulse = repeat tick AND repeat_en (registered); timer runs regardless of repeat_en.
REQ-021 press_pulse, release_pulse, repeat_pulse SHALL never assert in the same cycle as each other.
REQ-022 Counters SHALL be width $clog2(max value + 1); counters saturate, never wrap.
REQ-023 Latency sig_sync edge to accepted output: exactly DEBOUNCE_CYCLES sample edges, outputs registered.

Reset
REQ-024 rst=1 SHALL immediately (no clock edge) force state IDLE, all counters 0, all outputs 0.
REQ-025 After rst deasserts with sig_sync=1, a fresh DEBOUNCE_CYCLES samples SHALL be required before press_pulse.
REQ-026 Reset mid-HELD SHALL produce no release_pulse.

Structure
REQ-027 Shared package alarm_pkg SHALL hold the FSM state typedef and default timing constants (DEBOUNCE, REPEAT_DELAY, REPEAT_PERIOD for 100 MHz).
REQ-028 One sub-module button_timer (saturating up-counter with clear and enable, parameterized width) SHALL be instantiated twice: debounce count and hold timer.

Verification (bench params DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-029 sig_sync=1 for 3 cycles then 0 -> pressed stays 0, no pulses.
REQ-030 sig_sync=1 from edge k, held -> pressed=1 and press_pulse=1 for one cycle after edge k+3.
REQ-031 hold 30 cycles, repeat_en=1 -> repeat_pulse at 10, 13, 16, 19, 22, 25, 28 cycles after press_pulse.
REQ-032 release with bounce 0,1,0,0,0,0 -> pressed stays 1 through bounce; release_pulse once after 4th consecutive 0; no repeat_pulse during CONFIRM_RELEASE.
REQ-033 rst asserted between clock edges while HELD -> all outputs 0 before next edge; no release_pulse; re-press needs 4 samples.
REQ-034 repeat_en=0, hold 30 cycles -> no repeat_pulse; setting repeat_en=1 at cycle 15 -> next pulse at cycle 16.
